// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator.
// Holds the state encoding, exception bit position and reset vector.
package fetch_pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int          ADEL_BIT         = 16;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;

    // Next fetch-group base: align down to the group, then step one group.
    function automatic logic [31:0] seq_pc(
        input logic [31:0] cur,
        input logic [31:0] grp
    );
        return (cur & ~(grp - 32'd1)) + grp;
    endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// One-entry pending-redirect register and redirect priority mux.
// A flush always wins; a branch never displaces a pending flush.
module fetch_redirect_buf
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] BR_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        branch_ok,
    input  logic        accept,
    output logic        apply,
    output logic [31:0] target
);

    logic        pend_valid;
    logic        pend_flush;
    logic [31:0] pend_target;
    logic        br_en;
    logic [31:0] br_tgt;
    logic        redirect;

    assign br_en  = branch_flag & branch_ok;
    assign br_tgt = branch_target + BR_OFFSET;
    assign apply  = redirect & accept;

    // Pick the highest-priority redirect source for this cycle.
    always_comb begin
        redirect = 1'b0;
        target   = 32'd0;
        if (flush) begin
            redirect = 1'b1;
            target   = new_pc;
        end else if (pend_valid && pend_flush) begin
            redirect = 1'b1;
            target   = pend_target;
        end else if (br_en) begin
            redirect = 1'b1;
            target   = br_tgt;
        end else if (pend_valid && branch_ok) begin
            redirect = 1'b1;
            target   = pend_target;
        end
    end

    // Park a redirect that cannot be taken while a request is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_flush  <= 1'b0;
            pend_target <= 32'd0;
        end else if (accept) begin
            pend_valid  <= 1'b0;
            pend_flush  <= 1'b0;
        end else if (flush) begin
            pend_valid  <= 1'b1;
            pend_flush  <= 1'b1;
            pend_target <= new_pc;
        end else if (br_en && !(pend_valid && pend_flush)) begin
            pend_valid  <= 1'b1;
            pend_flush  <= 1'b0;
            pend_target <= br_tgt;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential fetch groups, redirects, AdEL halt.
// Request handshake is valid/ready; pc only moves on accept or redirect.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int          FETCH_WIDTH  = 1,
    parameter logic [31:0] BR_OFFSET    = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [31:0]            new_pc,
    input  logic                   branch_flag_i,
    input  logic [31:0]            branch_target_address_i,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [31:0]            pc,
    output logic                   ce,
    output logic [FETCH_WIDTH-1:0] slot_mask,
    output logic                   epoch,
    output logic [31:0]            excepttype_o
);

    localparam logic [31:0] GROUP = 32'(4 * FETCH_WIDTH);

    if (FETCH_WIDTH != 1 && FETCH_WIDTH != 2 && FETCH_WIDTH != 4) begin : g_bad_fw
        $error("FETCH_WIDTH must be 1, 2 or 4");
    end

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic        epoch_q;
    logic        adel;
    logic        accept;
    logic        handshake;
    logic        apply;
    logic [31:0] target;

    assign pc        = pc_q;
    assign epoch     = epoch_q;
    assign adel      = (pc_q[1:0] != 2'b00);
    assign accept    = ~req_valid | req_ready;
    assign handshake = req_valid & req_ready;

    fetch_redirect_buf #(
        .BR_OFFSET(BR_OFFSET)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .new_pc       (new_pc),
        .branch_flag  (branch_flag_i),
        .branch_target(branch_target_address_i),
        .branch_ok    (state != ST_HALT),
        .accept       (accept),
        .apply        (apply),
        .target       (target)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state: one idle cycle, halt on AdEL, leave halt only on flush.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: state_nx = ST_RUN;
            ST_RUN:  if (adel && !flush) state_nx = ST_HALT;
            ST_HALT: if (flush) state_nx = ST_RUN;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and current pc.
    always_comb begin
        ce           = (state != ST_IDLE);
        req_valid    = (state == ST_RUN) & ~stall & ~adel;
        excepttype_o = 32'd0;
        excepttype_o[ADEL_BIT] = adel;
    end

    // PC and epoch: redirect beats sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            epoch_q <= 1'b0;
        end else if (apply) begin
            pc_q    <= target;
            epoch_q <= ~epoch_q;
        end else if (handshake) begin
            pc_q    <= seq_pc(pc_q, GROUP);
        end
    end

    if (FETCH_WIDTH == 1) begin : g_mask1
        assign slot_mask = 1'b1;
    end else begin : g_maskn
        localparam int IW = $clog2(FETCH_WIDTH);
        logic [IW-1:0] idx;
        assign idx = pc_q[IW+1:2];
        // Slots at or after the entry word of the group are valid.
        always_comb begin
            slot_mask = '0;
            for (int i = 0; i < FETCH_WIDTH; i++)
                slot_mask[i] = (IW'(i) >= idx);
        end
    end

endmodule
